// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants and types for the sprite line buffer
// Purpose: line geometry, transparent pixel value, pixel/column types and the
//          draw-state encoding used by sprite_linebuf_scanout and linebuf_ram.
// Ports:   none (package).
package sprite_pkg;

    localparam int          H_VISIBLE      = 640;
    localparam logic [10:0] HCOUNT_MAX     = 11'd1599;
    localparam logic [10:0] HCOUNT_VIS_END = 11'd1280;   // 2 clk per visible pixel
    localparam logic [15:0] CLEAR_VALUE    = 16'h0000;

    typedef logic [15:0] pixel_t;
    typedef logic [9:0]  col_t;

    typedef enum logic {
        IDLE    = 1'b0,
        DRAWING = 1'b1
    } draw_state_t;

endpackage

// File: rtl/linebuf_ram.sv
// rtl/linebuf_ram.sv - one line of sprite pixels, write port A plus sync read/write port B
// Purpose: DEPTH x 16 storage. Port A is the draw-side write port; port B is the
//          scanout port (registered read, write used to clear after read).
//          Contents are deliberately not reset.
// Ports:   clk; i_a_we/i_a_addr/i_a_wdata (write A);
//          i_b_re/i_b_we/i_b_addr/i_b_wdata/o_b_rdata (port B).
module linebuf_ram
    import sprite_pkg::*;
#(
    parameter int DEPTH = H_VISIBLE
) (
    input  logic        clk,
    input  logic        i_a_we,
    input  logic [9:0]  i_a_addr,
    input  logic [15:0] i_a_wdata,
    input  logic        i_b_re,
    input  logic        i_b_we,
    input  logic [9:0]  i_b_addr,
    input  logic [15:0] i_b_wdata,
    output logic [15:0] o_b_rdata
);

    pixel_t r_mem [0:DEPTH-1];

    // Both writes live in one process so the array has a single driver; the
    // top never enables A and B on the same instance at once.
    always_ff @(posedge clk) begin
        if (i_a_we) begin
            r_mem[i_a_addr] <= i_a_wdata;
        end
        if (i_b_we) begin
            r_mem[i_b_addr] <= i_b_wdata;
        end
        if (i_b_re) begin
            o_b_rdata <= r_mem[i_b_addr];
        end
    end

endmodule

// File: rtl/sprite_linebuf_scanout.sv
// rtl/sprite_linebuf_scanout.sv - ping-pong sprite line buffer feeding VGA scanout
// Purpose: draw side writes line N+1 into the back buffer while line N is read
//          out of the front buffer and cleared behind the read. Buffers swap at
//          hcount == HCOUNT_MAX, followed one clock later by sprite_start.
// Ports:   clk, reset (async, active low); hcount/vcount (VGA counters);
//          sprite_pixel_col/sprite_pixel_data/wren_pixel_draw (draw writes);
//          engine_done (line complete level); sprite_start (1-clk pulse);
//          pix_out/pix_valid (scanned pixel, 2 clk after its hcount);
//          overrun (sticky) and overrun_clr.
module sprite_linebuf_scanout
    import sprite_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic [9:0]  sprite_pixel_col,
    input  logic [15:0] sprite_pixel_data,
    input  logic        wren_pixel_draw,
    input  logic        engine_done,
    output logic        sprite_start,
    output logic [15:0] pix_out,
    output logic        pix_valid,
    output logic        overrun,
    input  logic        overrun_clr
);

    logic        r_sel;          // index of the front (scanout) buffer
    logic [1:0]  r_warm_cnt;     // completed swaps since reset, saturates at 2
    draw_state_t r_state;

    // Scan pipeline stage 1: describes the read issued in the previous cycle.
    logic        r_rd_phase;
    logic        r_rd_vis;
    col_t        r_rd_col;

    logic        w_swap;
    logic        w_draw_we;
    logic        w_scan_rd;
    logic        w_scan_clr;
    logic        w_warm;
    pixel_t      w_rdata0;
    pixel_t      w_rdata1;
    pixel_t      w_front_rdata;
    logic        w_unused_vcount;

    assign w_swap     = (hcount == HCOUNT_MAX);
    assign w_draw_we  = wren_pixel_draw && (sprite_pixel_col < col_t'(H_VISIBLE));
    assign w_scan_rd  = !hcount[0] && (hcount < HCOUNT_VIS_END);
    assign w_scan_clr = r_rd_phase && r_rd_vis;
    assign w_warm     = (r_warm_cnt == 2'd2);

    // Reads happen on even hcount < 1280 and the swap on odd 1599, so r_sel is
    // unchanged between a read and its data, and this mux picks the same buffer.
    assign w_front_rdata = r_sel ? w_rdata1 : w_rdata0;

    assign w_unused_vcount = ^vcount;

    // Buffer 0 is front when r_sel == 0; buffer 1 otherwise. The draw port only
    // touches the back buffer and the scan port only the front buffer.
    linebuf_ram u_buf0 (
        .clk       (clk),
        .i_a_we    (w_draw_we && r_sel),
        .i_a_addr  (sprite_pixel_col),
        .i_a_wdata (sprite_pixel_data),
        .i_b_re    (w_scan_rd && !r_sel),
        .i_b_we    (w_scan_clr && !r_sel),
        .i_b_addr  (w_scan_clr ? r_rd_col : hcount[10:1]),
        .i_b_wdata (CLEAR_VALUE),
        .o_b_rdata (w_rdata0)
    );

    linebuf_ram u_buf1 (
        .clk       (clk),
        .i_a_we    (w_draw_we && !r_sel),
        .i_a_addr  (sprite_pixel_col),
        .i_a_wdata (sprite_pixel_data),
        .i_b_re    (w_scan_rd && r_sel),
        .i_b_we    (w_scan_clr && r_sel),
        .i_b_addr  (w_scan_clr ? r_rd_col : hcount[10:1]),
        .i_b_wdata (CLEAR_VALUE),
        .o_b_rdata (w_rdata1)
    );

    // Swap, start pulse, warm-up, draw-state FSM and overrun flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel        <= 1'b0;
            r_warm_cnt   <= 2'd0;
            r_state      <= IDLE;
            sprite_start <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sprite_start <= w_swap;

            if (w_swap) begin
                r_sel <= !r_sel;
                if (r_warm_cnt != 2'd2) begin
                    r_warm_cnt <= r_warm_cnt + 2'd1;
                end
            end

            // Set beats clear when both land in the same cycle.
            if (w_swap && (r_state == DRAWING)) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (sprite_start) begin
                        r_state <= DRAWING;
                    end
                end
                DRAWING: begin
                    // engine_done during a start pulse belongs to the previous
                    // line and must not end the new one.
                    if (!sprite_start && engine_done) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Scanout pipeline: read at T, clear at T+1, pix_out visible from T+2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_phase <= 1'b0;
            r_rd_vis   <= 1'b0;
            r_rd_col   <= '0;
            pix_out    <= '0;
            pix_valid  <= 1'b0;
        end else begin
            r_rd_phase <= !hcount[0];
            r_rd_vis   <= (hcount < HCOUNT_VIS_END);
            r_rd_col   <= hcount[10:1];

            if (r_rd_phase) begin
                pix_out   <= r_rd_vis ? w_front_rdata : '0;
                pix_valid <= r_rd_vis && (w_front_rdata != CLEAR_VALUE) && w_warm;
            end
        end
    end

endmodule

// File: tb/tb_sprite_linebuf_scanout.sv
// tb/tb_sprite_linebuf_scanout.sv - directed line-by-line bench for sprite_linebuf_scanout
module tb_sprite_linebuf_scanout;

    logic        clk;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [9:0]  sprite_pixel_col;
    logic [15:0] sprite_pixel_data;
    logic        wren_pixel_draw;
    logic        engine_done;
    logic        sprite_start;
    logic [15:0] pix_out;
    logic        pix_valid;
    logic        overrun;
    logic        overrun_clr;

    int n_checks = 0;
    int n_errors = 0;

    // Per-line stimulus configuration
    int          done_at;
    int          clr_a;
    int          clr_b;
    int          rst_from;
    int          rst_to;
    int          wr_h [$];
    logic [9:0]  wr_c [$];
    logic [15:0] wr_d [$];

    // Per-cycle observations of the last line, indexed by hcount
    logic [15:0] rec_pix   [0:1599];
    logic        rec_val   [0:1599];
    logic        rec_start [0:1599];
    logic        rec_ovr   [0:1599];

    sprite_linebuf_scanout dut (
        .clk               (clk),
        .reset             (reset),
        .hcount            (hcount),
        .vcount            (vcount),
        .sprite_pixel_col  (sprite_pixel_col),
        .sprite_pixel_data (sprite_pixel_data),
        .wren_pixel_draw   (wren_pixel_draw),
        .engine_done       (engine_done),
        .sprite_start      (sprite_start),
        .pix_out           (pix_out),
        .pix_valid         (pix_valid),
        .overrun           (overrun),
        .overrun_clr       (overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cfg_default();
        done_at  = 100;
        clr_a    = -1;
        clr_b    = -1;
        rst_from = -1;
        rst_to   = -1;
        wr_h.delete();
        wr_c.delete();
        wr_d.delete();
    endtask

    task automatic add_wr(input int h, input logic [9:0] c, input logic [15:0] d);
        wr_h.push_back(h);
        wr_c.push_back(c);
        wr_d.push_back(d);
    endtask

    task automatic run_line(input int line);
        vcount = line[9:0];
        for (int c = 0; c < 1600; c++) begin
            hcount            = c[10:0];
            wren_pixel_draw   = 1'b0;
            sprite_pixel_col  = '0;
            sprite_pixel_data = '0;
            for (int i = 0; i < wr_h.size(); i++) begin
                if (wr_h[i] == c) begin
                    wren_pixel_draw   = 1'b1;
                    sprite_pixel_col  = wr_c[i];
                    sprite_pixel_data = wr_d[i];
                end
            end
            engine_done = (c == done_at);
            overrun_clr = (c == clr_a) || (c == clr_b);
            reset       = !((c >= rst_from) && (c <= rst_to));
            #1;
            rec_pix[c]   = pix_out;
            rec_val[c]   = pix_valid;
            rec_start[c] = sprite_start;
            rec_ovr[c]   = overrun;
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int count_valid();
        int n = 0;
        for (int i = 0; i < 1600; i++) n += int'(rec_val[i]);
        return n;
    endfunction

    function automatic int count_start();
        int n = 0;
        for (int i = 0; i < 1600; i++) n += int'(rec_start[i]);
        return n;
    endfunction

    initial begin
        reset             = 1'b0;
        hcount            = '0;
        vcount            = '0;
        sprite_pixel_col  = '0;
        sprite_pixel_data = '0;
        wren_pixel_draw   = 1'b0;
        engine_done       = 1'b0;
        overrun_clr       = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_start", sprite_start, 0);
        check("rst_pix", pix_out, 0);
        check("rst_valid", pix_valid, 0);
        check("rst_overrun", overrun, 0);

        // Lines 0..2: warm-up, no draw writes
        for (int ln = 0; ln < 3; ln++) begin
            cfg_default();
            run_line(ln);
            check($sformatf("warm%0d_valid_cnt", ln), count_valid(), 0);
            check($sformatf("warm%0d_start_cnt", ln), count_start(), (ln == 0) ? 0 : 1);
            if (ln != 0) check($sformatf("warm%0d_start_h0", ln), rec_start[0], 1);
        end

        // Line 3: draw col 100, col 639 and an out-of-range col 640
        cfg_default();
        add_wr(50, 10'd100, 16'hF800);
        add_wr(60, 10'd639, 16'h07E0);
        add_wr(61, 10'd640, 16'hFFFF);
        run_line(3);
        check("l3_valid_cnt", count_valid(), 0);
        check("l3_overrun", rec_ovr[1599], 0);

        // Line 4: display them; swap-edge write to col 5 at hcount 1599
        cfg_default();
        add_wr(1599, 10'd5, 16'h1234);
        run_line(4);
        check("l4_valid_cnt", count_valid(), 4);
        check("l4_pix202", rec_pix[202], 16'hF800);
        check("l4_val202", rec_val[202], 1);
        check("l4_val203", rec_val[203], 1);
        check("l4_val201", rec_val[201], 0);
        check("l4_val204", rec_val[204], 0);
        check("l4_pix1280", rec_pix[1280], 16'h07E0);
        check("l4_val1280", rec_val[1280], 1);
        check("l4_col0_pix", rec_pix[2], 0);
        check("l4_col0_val", rec_val[2], 0);

        // Line 5: swap-edge write appears here
        cfg_default();
        run_line(5);
        check("l5_valid_cnt", count_valid(), 2);
        check("l5_pix12", rec_pix[12], 16'h1234);
        check("l5_val12", rec_val[12], 1);
        check("l5_val10", rec_val[10], 0);

        // Line 6: buffer read on line 4 has been cleared
        cfg_default();
        run_line(6);
        check("l6_valid_cnt", count_valid(), 0);
        check("l6_pix202", rec_pix[202], 0);
        check("l6_pix1280", rec_pix[1280], 0);

        // Line 7: engine_done withheld across the swap
        cfg_default();
        done_at = -1;
        run_line(7);
        check("l7_ovr_end", rec_ovr[1599], 0);

        // Line 8: overrun visible; done on the start cycle is ignored; clear,
        // then clear coincident with a new overrun
        cfg_default();
        done_at = 0;
        clr_a   = 10;
        clr_b   = 1599;
        run_line(8);
        check("l8_ovr_h0", rec_ovr[0], 1);
        check("l8_start_h0", rec_start[0], 1);
        check("l8_ovr_h10", rec_ovr[10], 1);
        check("l8_ovr_h11", rec_ovr[11], 0);

        // Line 9: set won over clear; then finish drawing and clear
        cfg_default();
        clr_a = 200;
        run_line(9);
        check("l9_ovr_h0", rec_ovr[0], 1);
        check("l9_start_h0", rec_start[0], 1);
        check("l9_ovr_h201", rec_ovr[201], 0);

        // Line 10: drawing completes? no - overrun again
        cfg_default();
        done_at = -1;
        run_line(10);
        check("l10_ovr_h0", rec_ovr[0], 0);

        // Line 11: overrun latched; write col 300 into the back buffer
        cfg_default();
        add_wr(500, 10'd300, 16'hAAAA);
        run_line(11);
        check("l11_ovr_h0", rec_ovr[0], 1);

        // Line 12: mid-line reset restarts warm-up
        cfg_default();
        rst_from = 100;
        rst_to   = 104;
        run_line(12);
        check("l12_ovr_pre", rec_ovr[99], 1);
        check("l12_ovr_rst", rec_ovr[102], 0);
        check("l12_ovr_end", rec_ovr[1599], 0);
        check("l12_start_cnt", count_start(), 1);
        check("l12_pix602", rec_pix[602], 16'hAAAA);
        check("l12_valid_cnt", count_valid(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sprite_linebuf_scanout.md
Name: sprite_linebuf_scanout

Overview:
Ping-pong line buffer between the sprite pipeline and the VGA scanout. It captures per-pixel sprite writes (col, data, wren) for line N+1 into the back buffer while scanning out line N from the front buffer. The front buffer is read-then-cleared as it is scanned. Buffers swap at each end of line, and the block issues the per-line start pulse to the sprite pipeline.

Parameters:
H_VISIBLE, 640, visible pixels per line (buffer depth)
HCOUNT_MAX, 1599, last hcount of a line (2 clk per pixel, 800 pixel periods)
CLEAR_VALUE, 16'h0000, transparent value written back after scanout read

Ports:
clk  input  1  system clock (pixel rate x2)
reset  input  1  asynchronous, active-low reset (asserted when 0)
hcount  input  11  VGA horizontal counter; pixel column = hcount[10:1]
vcount  input  10  VGA vertical counter (status only)
sprite_pixel_col  input  10  draw-side write column
sprite_pixel_data  input  16  draw-side write data
wren_pixel_draw  input  1  draw-side write strobe
engine_done  input  1  sprite pipeline line-complete level
sprite_start  output  1  one-cycle pulse: begin rendering next line
pix_out  output  16  scanned-out sprite pixel
pix_valid  output  1  pix_out is opaque and displayable
overrun  output  1  sticky: swap occurred while the line was still drawing
overrun_clr  input  1  clears overrun

Behaviour:
- Reset values: sel=0 (buffer 0 = front), sprite_start=0, pix_out=0, pix_valid=0, overrun=0, draw state IDLE, warm-up count=0.
- Draw port:
  - When wren_pixel_draw=1 and sprite_pixel_col < H_VISIBLE, write sprite_pixel_data into the back buffer (index !sel) at sprite_pixel_col in the same cycle.
  - Writes with col >= 640 are dropped.
  - Later writes to the same column overwrite earlier ones; the sprite pipeline owns priority ordering.
- Scanout, cycle T, hcount even and hcount < 1280:
  - Read front buffer at hcount[10:1].
  - Synchronous RAM data is available at T+1.
  - At T+1 (hcount odd), write CLEAR_VALUE to the same address in the front buffer.
  - At T+2, pix_out is registered with that data.
- Scanout latency: pix_out and pix_valid at T+2 correspond to hcount at T. For hcount >= 1280, register pix_out=0 and pix_valid=0 on the same pipeline.
- pix_valid = (data != CLEAR_VALUE) && visible && warm-up complete.
- Swap: on the cycle where hcount == HCOUNT_MAX, toggle sel. On the following cycle, pulse sprite_start for exactly 1 clk. This happens every line, including vblank; the pipeline handles vblank itself.
- Write on the swap cycle: a draw write coincident with hcount == HCOUNT_MAX uses the pre-toggle back buffer.
- Port ownership: the front buffer's draw port and the back buffer's scan port are idle, so there are no same-port conflicts.
- Draw-state FSM:
  - IDLE -> DRAWING on sprite_start.
  - DRAWING -> IDLE when engine_done=1, sampled no earlier than the cycle after sprite_start.
  - Swap while DRAWING: set overrun=1, still swap, still pulse sprite_start, and stay in DRAWING.
- Overrun clear: overrun_clr clears overrun. If set and clear occur in the same cycle, set wins.
- Warm-up:
  - RAM contents are undefined after reset. pix_valid is forced 0 until 2 swaps have completed, at which point both buffers have been scanned and cleared once.
  - The counter saturates at 2.
- Mid-line reset: all registers return to reset values immediately (async). On release, scanout restarts at the current hcount and warm-up restarts.
- Widths: column compare is 10-bit unsigned; hcount compares are 11-bit.

Decomposition:
- Package sprite_pkg: H_VISIBLE, HCOUNT_MAX, CLEAR_VALUE, pixel_t (logic [15:0]), col_t (logic [9:0]), draw-state enum {IDLE, DRAWING}.
- Sub-module linebuf_ram: simple 640x16 RAM with write port A and synchronous read/write port B, instantiated twice. Contents are not reset.

Test Plan:
- Warm-up: reset, run 3 lines with no draw writes -> pix_valid=0 throughout; sprite_start pulses once per line, 1 clk after hcount=1599.
- Basic draw: after warm-up, during line N write col=100 data=16'hF800 -> on line N+1, pix_out=16'hF800 and pix_valid=1 exactly 2 clk after hcount=200; all other columns invalid.
- Clear-after-read: same as the basic draw, then no writes during line N+1 -> on line N+2, col 100 reads 0 and pix_valid=0.
- Boundary writes: write col=639 data=16'h07E0 and col=640 data=16'hFFFF -> col 639 is displayed at hcount=1278 (+2 clk); no corruption of col 0 or any other column.
- Swap-edge write: a write on the cycle hcount=1599 to col=5 -> appears on the immediately following line, not the one after.
- Overrun: withhold engine_done across a swap -> overrun=1 and sprite_start still pulses; assert overrun_clr -> overrun=0; overrun_clr on the same cycle as a new overrun -> overrun stays 1.
